cpu_uart_port: RTL and testbench
================================

# cpu_uart_port

Peripheral end of the CPU I/O handshake. Serves the write channel (`w_req`/`w_data` in, `w_busy` out) by transmitting the low byte of `w_data` as an 8N1 UART frame. Serves the read/interrupt channel (`irr`/`r_data` out, `ack` in) by receiving 8N1 frames and raising `irr` until the CPU acknowledges. It sits between the CPU core and the board-level UART pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.

Ports:
- `clk`  in  1: system clock, all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `w_req`  in  1: CPU write request, sampled each cycle.
- `w_data`  in  32: write payload; only bits [7:0] are transmitted.
- `w_busy`  out  1: transmitter busy; a `w_req` is ignored while high.
- `irr`  out  1: received byte pending (interrupt request).
- `r_data`  out  32: received byte, zero-extended ({24'b0, byte}).
- `ack`  in  1: CPU acknowledge; clears `irr`.
- `uart_rx`  in  1: serial input, asynchronous to `clk`.
- `uart_tx`  out  1: serial output, idle high.
- `rx_overrun`  out  1: one-cycle pulse when a byte is dropped because `irr` was still set.
- `rx_frame_err`  out  1: one-cycle pulse when a stop bit samples low.

## Operation
Reset values: `uart_tx`=1, `w_busy`=0, `irr`=0, `r_data`=0, `rx_overrun`=0, `rx_frame_err`=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts the frame. No partial byte is delivered.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- IDLE: if `w_req`=1, latch `w_data[7:0]`, set `w_busy`=1 and go to START.
- START: drive `uart_tx`=0 for CLKS_PER_BIT cycles.
- DATA: drive 8 bits, LSB first, CLKS_PER_BIT cycles each. A 3-bit index advances at the end of each bit.
- STOP: drive `uart_tx`=1 for CLKS_PER_BIT cycles, then clear `w_busy` and return to IDLE.
- A `w_req` while `w_busy`=1 is ignored. It is not queued.
- `uart_tx`, `w_busy` and `irr` are registered outputs.

RX path: `uart_rx` passes through a 2-FF synchronizer (reset value 1) before use.

RX FSM: IDLE → START → DATA → STOP → IDLE.
- IDLE: a synchronized 0 enters START and clears the bit-timer.
- START: after CLKS_PER_BIT/2 cycles, re-sample the line. If 0, go to DATA. If 1, it was a false start: return to IDLE with no pulse.
- DATA: sample every CLKS_PER_BIT cycles (at bit centre), shifting LSB first, 8 samples.
- STOP: sample after CLKS_PER_BIT cycles.
  - If 1 and `irr`=0 (or `ack`=1 this cycle): load `r_data`={24'b0, byte} and set `irr`=1.
  - If 1 and `irr`=1 and `ack`=0: keep `r_data`, drop the byte, pulse `rx_overrun`.
  - If 0: pulse `rx_frame_err` and discard the byte.
  - Return to IDLE in all cases.

`irr` handling:
- `ack`=1 clears `irr` on the next edge.
- `ack` with `irr`=0 has no effect.
- `ack` in the same cycle as a valid byte completes: the new byte wins (`irr` stays 1, `r_data` updated, no overrun).
- `r_data` holds its value after `ack`.

TX and RX are fully independent. Simultaneous activity on both has no interaction.

## Timing
- `w_req` high at edge N (IDLE): `w_busy`=1 and `uart_tx`=0 from edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. `w_busy` falls at edge N+1+10·CLKS_PER_BIT.
- A new `w_req` is accepted in the same cycle `w_busy` reads 0. Back-to-back frames have no idle gap.
- RX latency: `irr` rises 2 (synchronizer) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (±1) cycles after the start-bit falling edge at the pin.
- `ack` at edge M: `irr`=0 after edge M.
- Error pulses are exactly one cycle, coincident with the stop-bit sample edge +1.

## Test plan
(All with CLKS_PER_BIT=4.)
- TX single: `w_req` one cycle with `w_data`=0xDEADBEA5 → `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each). `w_busy` high exactly 40 cycles.
- TX busy-ignore: second `w_req` (0x3C) 10 cycles into a frame → only the first frame is sent. A `w_req` (0x3C) on the cycle `w_busy`=0 → immediate second frame with 0x3C.
- RX + ack: drive frame 0x5A on `uart_rx` → `irr`=1, `r_data`=0x0000005A. `ack` one cycle → `irr`=0 next cycle, `r_data` still 0x5A.
- RX overrun: frame 0x11 then frame 0x22 without `ack` → `rx_overrun` pulse, `r_data`=0x11. Repeat with `ack` on the stop-sample cycle → `r_data`=0x22, no pulse.
- RX errors: a 1-cycle low glitch → no activity. Frame 0x77 with stop bit 0 → `rx_frame_err` pulse, `irr` unchanged.
- Reset mid-operation: assert `rst_n`=0 mid TX and RX frames → `uart_tx`=1, `w_busy`=0, `irr`=0, `r_data`=0 immediately. A clean frame after release is received correctly.

Source files
------------

// File: rtl/cpu_uart_port.sv
// cpu_uart_port: CPU-side UART peripheral. Transmits the low byte of each
// accepted write as an 8N1 frame and receives 8N1 frames into an
// interrupt-flagged read register.
//
// Both TX and RX use the same four-state sequence:
//   state    | meaning
//   ST_IDLE  | line idle, waiting for w_req (TX) or a synchronized low (RX)
//   ST_START | start bit: TX drives 0 for one bit, RX waits half a bit and re-checks
//   ST_DATA  | eight data bits, LSB first, one bit-time each
//   ST_STOP  | stop bit: TX drives 1, RX samples and delivers/drops the byte
module cpu_uart_port #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_req,
    input  logic [31:0] w_data,
    output logic        w_busy,
    output logic        irr,
    output logic [31:0] r_data,
    input  logic        ack,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        rx_overrun,
    output logic        rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // Only the low byte of a write is transmitted.
    logic unused_w_data;
    assign unused_w_data = ^w_data[31:8];

    uart_state_t      tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_idx, tx_idx_nxt;
    logic [7:0]       tx_byte, tx_byte_nxt;
    logic             tx_line_nxt, tx_busy_nxt;

    uart_state_t      rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_idx, rx_idx_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [7:0]       r_byte, r_byte_nxt;
    logic             irr_nxt, overrun_nxt, frame_err_nxt;
    logic [1:0]       rx_sync;
    logic             rx_s;

    assign rx_s   = rx_sync[1];
    assign r_data = {24'b0, r_byte};

    // TX state register; uart_tx and w_busy are registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            uart_tx  <= 1'b1;
            w_busy   <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_byte  <= tx_byte_nxt;
            uart_tx  <= tx_line_nxt;
            w_busy   <= tx_busy_nxt;
        end
    end

    // TX next state: bit-timer counts down and each state advances at terminal count.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_byte_nxt  = tx_byte;
        tx_line_nxt  = uart_tx;
        tx_busy_nxt  = w_busy;
        case (tx_state)
            ST_IDLE: begin
                if (w_req) begin
                    tx_byte_nxt  = w_data[7:0];
                    tx_busy_nxt  = 1'b1;
                    tx_line_nxt  = 1'b0;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == '0) begin
                    tx_line_nxt  = tx_byte[0];
                    tx_idx_nxt   = 3'd0;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_state_nxt = ST_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = BIT_LAST;
                    if (tx_idx == 3'd7) begin
                        tx_line_nxt  = 1'b1;
                        tx_state_nxt = ST_STOP;
                    end else begin
                        tx_idx_nxt  = tx_idx + 3'd1;
                        tx_line_nxt = tx_byte[tx_idx + 3'd1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt == '0) begin
                    tx_busy_nxt  = 1'b0;
                    tx_state_nxt = ST_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], uart_rx};
    end

    // RX state register plus the read register, irr and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= ST_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            r_byte       <= '0;
            irr          <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_idx       <= rx_idx_nxt;
            rx_shift     <= rx_shift_nxt;
            r_byte       <= r_byte_nxt;
            irr          <= irr_nxt;
            rx_overrun   <= overrun_nxt;
            rx_frame_err <= frame_err_nxt;
        end
    end

    // RX next state: half-bit wait to reach bit centre, then full-bit samples.
    // A byte completing in the same cycle as ack replaces the pending one.
    always_comb begin
        rx_state_nxt  = rx_state;
        rx_cnt_nxt    = rx_cnt;
        rx_idx_nxt    = rx_idx;
        rx_shift_nxt  = rx_shift;
        r_byte_nxt    = r_byte;
        irr_nxt       = irr & ~ack;
        overrun_nxt   = 1'b0;
        frame_err_nxt = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_nxt   = HALF_LAST;
                    rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_s) begin
                        rx_cnt_nxt   = BIT_LAST;
                        rx_idx_nxt   = 3'd0;
                        rx_state_nxt = ST_DATA;
                    end else begin
                        rx_state_nxt = ST_IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    rx_cnt_nxt   = BIT_LAST;
                    if (rx_idx == 3'd7) rx_state_nxt = ST_STOP;
                    else                rx_idx_nxt   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = ST_IDLE;
                    if (rx_s) begin
                        if (!irr || ack) begin
                            r_byte_nxt = rx_shift;
                            irr_nxt    = 1'b1;
                        end else begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_uart_port.sv
// Directed testbench for cpu_uart_port with CLKS_PER_BIT = 4.
module tb_cpu_uart_port;

    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_req = 1'b0;
    logic [31:0] w_data = '0;
    logic        ack = 1'b0;
    logic        uart_rx = 1'b1;
    logic        w_busy, irr, uart_tx, rx_overrun, rx_frame_err;
    logic [31:0] r_data;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_uart_port #(.CLKS_PER_BIT(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_req       (w_req),
        .w_data      (w_data),
        .w_busy      (w_busy),
        .irr         (irr),
        .r_data      (r_data),
        .ack         (ack),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle uart_tx waveform for one frame: start, 8 data LSB first, stop.
    function automatic logic [39:0] expand_frame(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] e;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) e[k] = f[k / K];
        return e;
    endfunction

    // Issue a one-cycle write; returns just after the capturing edge.
    task automatic start_tx(input logic [31:0] d);
        w_data = d;
        w_req  = 1'b1;
        step();
        w_req  = 1'b0;
    endtask

    // Record uart_tx and count w_busy over 40 cycles; optionally pulse w_req at cycle req_at.
    task automatic capture_tx(input int req_at, input logic [31:0] req_data,
                              output logic [39:0] bits, output int busy_cnt);
        bits = '0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            bits[k] = uart_tx;
            if (w_busy) busy_cnt++;
            if (k == req_at) begin
                w_req  = 1'b1;
                w_data = req_data;
            end else begin
                w_req = 1'b0;
            end
            step();
        end
        w_req = 1'b0;
    endtask

    // Drive one 8N1 frame on uart_rx; returns one cycle before the DUT's stop sample edge.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        step();
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (K) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        n_tests++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset_w_busy: got %b want 0", w_busy); end
        n_tests++; if (irr !== 1'b0) begin n_fail++; $display("FAIL reset_irr: got %b want 0", irr); end
        n_tests++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL reset_r_data: got %h want 0", r_data); end
        n_tests++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {rx_overrun, rx_frame_err}); end
        rst_n = 1'b1;
        repeat (3) step();
        n_tests++; if ({uart_tx, w_busy, irr} !== 3'b100) begin n_fail++; $display("FAIL post_reset_idle: got %b want 100", {uart_tx, w_busy, irr}); end
    endtask

    task automatic test_tx_single();
        logic [39:0] bits;
        int          busy;
        start_tx(32'hDEADBEA5);
        capture_tx(-1, 32'h0, bits, busy);
        n_tests++; if (bits !== expand_frame(8'hA5)) begin n_fail++; $display("FAIL tx_single_wave: got %h want %h", bits, expand_frame(8'hA5)); end
        n_tests++; if (busy != 40) begin n_fail++; $display("FAIL tx_single_busy_cycles: got %0d want 40", busy); end
        n_tests++; if ({w_busy, uart_tx} !== 2'b01) begin n_fail++; $display("FAIL tx_single_end: busy/tx got %b want 01", {w_busy, uart_tx}); end
    endtask

    task automatic test_tx_busy_ignore();
        logic [39:0] bits;
        int          busy;
        repeat (3) step();
        start_tx(32'h00000081);
        capture_tx(10, 32'h0000003C, bits, busy);
        n_tests++; if (bits !== expand_frame(8'h81)) begin n_fail++; $display("FAIL tx_ignore_wave: got %h want %h", bits, expand_frame(8'h81)); end
        n_tests++; if (busy != 40) begin n_fail++; $display("FAIL tx_ignore_busy_cycles: got %0d want 40", busy); end
        repeat (6) step();
        n_tests++; if ({w_busy, uart_tx} !== 2'b01) begin n_fail++; $display("FAIL tx_ignore_not_queued: busy/tx got %b want 01", {w_busy, uart_tx}); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] bits;
        int          busy;
        start_tx(32'h000000C6);
        capture_tx(-1, 32'h0, bits, busy);
        n_tests++; if (bits !== expand_frame(8'hC6)) begin n_fail++; $display("FAIL b2b_first_wave: got %h want %h", bits, expand_frame(8'hC6)); end
        n_tests++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_low: got %b want 0", w_busy); end
        start_tx(32'h0000003C);
        capture_tx(-1, 32'h0, bits, busy);
        n_tests++; if (bits !== expand_frame(8'h3C)) begin n_fail++; $display("FAIL b2b_second_wave: got %h want %h", bits, expand_frame(8'h3C)); end
        n_tests++; if (busy != 40) begin n_fail++; $display("FAIL b2b_second_busy: got %0d want 40", busy); end
    endtask

    task automatic test_rx_ack();
        send_rx(8'h5A, 1'b1);
        step();
        n_tests++; if (irr !== 1'b1) begin n_fail++; $display("FAIL rx_irr_set: got %b want 1", irr); end
        n_tests++; if (r_data !== 32'h0000005A) begin n_fail++; $display("FAIL rx_data: got %h want 0000005a", r_data); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++; if (irr !== 1'b0) begin n_fail++; $display("FAIL rx_ack_clear: got %b want 0", irr); end
        n_tests++; if (r_data !== 32'h0000005A) begin n_fail++; $display("FAIL rx_ack_hold: got %h want 0000005a", r_data); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++; if ({irr, r_data} !== {1'b0, 32'h0000005A}) begin n_fail++; $display("FAIL rx_ack_idle: irr/data got %b/%h want 0/0000005a", irr, r_data); end
    endtask

    task automatic test_rx_overrun();
        send_rx(8'h11, 1'b1);
        step();
        n_tests++; if ({irr, r_data} !== {1'b1, 32'h00000011}) begin n_fail++; $display("FAIL ovr_first: irr/data got %b/%h want 1/00000011", irr, r_data); end
        repeat (3) step();
        send_rx(8'h22, 1'b1);
        step();
        n_tests++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b want 1", rx_overrun); end
        n_tests++; if ({irr, r_data} !== {1'b1, 32'h00000011}) begin n_fail++; $display("FAIL ovr_keep: irr/data got %b/%h want 1/00000011", irr, r_data); end
        step();
        n_tests++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b want 0", rx_overrun); end
        repeat (2) step();
        send_rx(8'h22, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_tests++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ack_race_no_pulse: got %b want 0", rx_overrun); end
        n_tests++; if ({irr, r_data} !== {1'b1, 32'h00000022}) begin n_fail++; $display("FAIL ack_race_new_wins: irr/data got %b/%h want 1/00000022", irr, r_data); end
    endtask

    task automatic test_rx_errors();
        logic seen;
        repeat (3) step();
        send_rx(8'h77, 1'b0);
        step();
        n_tests++; if (rx_frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_pulse: got %b want 1", rx_frame_err); end
        n_tests++; if ({irr, r_data, rx_overrun} !== {1'b1, 32'h00000022, 1'b0}) begin n_fail++; $display("FAIL frame_err_state: irr/data/ovr got %b/%h/%b want 1/00000022/0", irr, r_data, rx_overrun); end
        step();
        n_tests++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_one_cycle: got %b want 0", rx_frame_err); end
        repeat (10) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        uart_rx = 1'b0;
        step();
        uart_rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= irr | rx_overrun | rx_frame_err;
            step();
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_activity: got %b want 0", seen); end
        n_tests++; if (r_data !== 32'h00000022) begin n_fail++; $display("FAIL glitch_data: got %h want 00000022", r_data); end
        send_rx(8'h96, 1'b1);
        step();
        n_tests++; if ({irr, r_data} !== {1'b1, 32'h00000096}) begin n_fail++; $display("FAIL after_glitch_rx: irr/data got %b/%h want 1/00000096", irr, r_data); end
    endtask

    task automatic test_reset_mid();
        start_tx(32'h0000FF00);
        uart_rx = 1'b0;
        repeat (10) step();
        uart_rx = 1'b1;
        repeat (5) step();
        n_tests++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", w_busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({uart_tx, w_busy, irr} !== 3'b100) begin n_fail++; $display("FAIL mid_reset_ctrl: tx/busy/irr got %b want 100", {uart_tx, w_busy, irr}); end
        n_tests++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0", r_data); end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (50) step();
        n_tests++; if ({uart_tx, w_busy, irr, rx_frame_err} !== 4'b1000) begin n_fail++; $display("FAIL mid_after_release: tx/busy/irr/ferr got %b want 1000", {uart_tx, w_busy, irr, rx_frame_err}); end
        send_rx(8'hC3, 1'b1);
        step();
        n_tests++; if ({irr, r_data} !== {1'b1, 32'h000000C3}) begin n_fail++; $display("FAIL mid_clean_rx: irr/data got %b/%h want 1/000000c3", irr, r_data); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_busy_ignore();
        test_back_to_back();
        test_rx_ack();
        test_rx_overrun();
        test_rx_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
